// File: rtl/max7219_ctrl_if.sv
// rtl/max7219_ctrl_if.sv - user data/strobe and MAX7219 serial pins bundled for max7219_ctrl
//
// Signals:
//   value    [31:0] eight hex nibbles, nibble k shown on digit register k+1
//   dp       [7:0]  decimal point per digit, dp[k] on digit register k+1
//   update          single-cycle strobe capturing value/dp
//   busy            high while a frame is running or a refresh is pending
//   done            one-cycle pulse after the last digit frame of a refresh
//   spi_cs          MAX7219 LOAD, active low
//   spi_clk         MAX7219 CLK
//   spi_mosi        MAX7219 DIN
// Modports:
//   master  user logic / bench side (drives value, dp, update)
//   slave   controller side (drives status and the serial pins)

interface max7219_ctrl_if;
    logic [31:0] value;
    logic [7:0]  dp;
    logic        update;
    logic        busy;
    logic        done;
    logic        spi_cs;
    logic        spi_clk;
    logic        spi_mosi;

    modport master (
        output value, dp, update,
        input  busy, done, spi_cs, spi_clk, spi_mosi
    );

    modport slave (
        input  value, dp, update,
        output busy, done, spi_cs, spi_clk, spi_mosi
    );
endinterface

// File: rtl/max7219_ctrl.sv
// rtl/max7219_ctrl.sv - MAX7219 8-digit controller: init sequence, digit refresh, serial frame engine
//
// sseg_decoder
//   nibble_i [3:0]  hex digit
//   seg_n_o  [6:0]  active-low segments {G,F,E,D,C,B,A}
//
// max7219_ctrl
//   CLK_DIV         spi_clk half-period in clk cycles (>= 1)
//   INTENSITY       value written to the intensity register 0x0A
//   clk             system clock
//   rst_n           synchronous active-low reset
//   bus             max7219_ctrl_if.slave (value/dp/update in, busy/done/spi_* out)

module sseg_decoder (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);
    // Lit segments, active high, bit order {g,f,e,d,c,b,a}.
    logic [6:0] seg_on;

    always_comb begin
        case (nibble_i)
            4'h0:    seg_on = 7'h3F;
            4'h1:    seg_on = 7'h06;
            4'h2:    seg_on = 7'h5B;
            4'h3:    seg_on = 7'h4F;
            4'h4:    seg_on = 7'h66;
            4'h5:    seg_on = 7'h6D;
            4'h6:    seg_on = 7'h7D;
            4'h7:    seg_on = 7'h07;
            4'h8:    seg_on = 7'h7F;
            4'h9:    seg_on = 7'h6F;
            4'hA:    seg_on = 7'h77;
            4'hB:    seg_on = 7'h7C;
            4'hC:    seg_on = 7'h39;
            4'hD:    seg_on = 7'h5E;
            4'hE:    seg_on = 7'h79;
            default: seg_on = 7'h71;
        endcase
    end

    assign seg_n_o = ~seg_on;
endmodule

module max7219_ctrl #(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [3:0]  INTENSITY = 4'h8
) (
    input  logic          clk,
    input  logic          rst_n,
    max7219_ctrl_if.slave bus
);
    localparam int unsigned     DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // A frame is 35 phases of CLK_DIV cycles each:
    //   0        SETUP (cs low, clk low, first bit on mosi)
    //   1..31    odd = clk high for a bit, even = clk low with next bit
    //   32       HOLD
    //   33..34   GAP (cs high)
    localparam logic [5:0] PH_HOLD = 6'd32;
    localparam logic [5:0] PH_LAST = 6'd34;

    localparam logic [1:0] ST_INIT    = 2'd0;
    localparam logic [1:0] ST_REFRESH = 2'd1;
    localparam logic [1:0] ST_IDLE    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             active_q, active_d;
    logic [5:0]       ph_q, ph_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [31:0]      shadow_val_q, shadow_val_d;
    logic [7:0]       shadow_dp_q, shadow_dp_d;
    logic [31:0]      pend_val_q, pend_val_d;
    logic [7:0]       pend_dp_q, pend_dp_d;
    logic             pend_q, pend_d;
    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             frame_end;
    logic [3:0]       nibble;
    logic [6:0]       seg_n;
    logic [7:0]       digit_byte;
    logic [15:0]      word;
    logic [3:0]       bit_sel;

    // Sequencing: frame engine advance, top FSM, shadow/pending data.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        active_d     = active_q;
        ph_d         = ph_q;
        div_d        = div_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_d       = pend_q;

        frame_end = active_q && (ph_q == PH_LAST) && (div_q == DIV_LAST);

        // Outside IDLE the shadow must stay frozen, so updates go to pending (latest wins).
        if (bus.update && (state_q != ST_IDLE)) begin
            pend_d     = 1'b1;
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp;
        end

        if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                ph_d  = ph_q + 6'd1;
            end else begin
                div_d = div_q + 1'b1;
            end
        end else if (state_q != ST_IDLE) begin
            active_d = 1'b1;
            ph_d     = '0;
            div_d    = '0;
        end

        // Frames run back to back; the next SETUP follows the last GAP cycle directly.
        if (frame_end) begin
            ph_d  = '0;
            div_d = '0;
            case (state_q)
                ST_INIT: begin
                    if (idx_q == 3'd4) begin
                        state_d = ST_REFRESH;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
                ST_REFRESH: begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else if (pend_q || bus.update) begin
                        // An update arriving on this very edge is newer than the pending copy.
                        shadow_val_d = bus.update ? bus.value : pend_val_q;
                        shadow_dp_d  = bus.update ? bus.dp    : pend_dp_q;
                        pend_d       = 1'b0;
                        idx_d        = '0;
                    end else begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if ((state_q == ST_IDLE) && bus.update) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp;
            state_d      = ST_REFRESH;
            idx_d        = '0;
        end
    end

    // Word for the frame described by the next-state values, so outputs can be registered.
    assign nibble = shadow_val_d[{idx_d, 2'b00} +: 4];

    sseg_decoder u_dec (
        .nibble_i (nibble),
        .seg_n_o  (seg_n)
    );

    // No-decode byte is {DP,A,B,C,D,E,F,G}; the decoder gives active-low {G..A}.
    assign digit_byte = {shadow_dp_d[idx_d], ~seg_n[0], ~seg_n[1], ~seg_n[2],
                         ~seg_n[3], ~seg_n[4], ~seg_n[5], ~seg_n[6]};

    always_comb begin
        word = 16'h0000;
        if (state_d == ST_INIT) begin
            case (idx_d)
                3'd0:    word = 16'h0F00;
                3'd1:    word = 16'h0B07;
                3'd2:    word = 16'h0900;
                3'd3:    word = {12'h0A0, INTENSITY};
                default: word = 16'h0C01;
            endcase
        end else begin
            word = {4'h0, {1'b0, idx_d} + 4'd1, digit_byte};
        end
    end

    // Phase p (p <= 31) carries bit 15 - p/2: SETUP and the first HIGH share bit 15.
    assign bit_sel = 4'd15 - ph_d[4:1];

    always_comb begin
        cs_d   = ~(active_d && (ph_d <= PH_HOLD));
        sck_d  = active_d && ph_d[0] && (ph_d < PH_HOLD);
        mosi_d = active_d && (ph_d < PH_HOLD) && word[bit_sel];
        busy_d = (state_d != ST_IDLE);
        done_d = active_d && (state_d == ST_REFRESH) && (idx_d == 3'd7) &&
                 (ph_d == PH_LAST) && (div_d == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_INIT;
            idx_q        <= '0;
            active_q     <= 1'b0;
            ph_q         <= '0;
            div_q        <= '0;
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_q       <= 1'b0;
            cs_q         <= 1'b1;
            sck_q        <= 1'b0;
            mosi_q       <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            ph_q         <= ph_d;
            div_q        <= div_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_q       <= pend_d;
            cs_q         <= cs_d;
            sck_q        <= sck_d;
            mosi_q       <= mosi_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.spi_cs   = cs_q;
    assign bus.spi_clk  = sck_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_max7219_ctrl.sv
// tb/tb_max7219_ctrl.sv - self-checking bench for max7219_ctrl (CLK_DIV=4 and CLK_DIV=1 instances)

module tb_max7219_ctrl;
    logic clk;
    logic rst_n0, rst_n1;

    max7219_ctrl_if b0 ();
    max7219_ctrl_if b1 ();

    max7219_ctrl #(.CLK_DIV(4), .INTENSITY(4'h8)) dut0 (.clk(clk), .rst_n(rst_n0), .bus(b0));
    max7219_ctrl #(.CLK_DIV(1), .INTENSITY(4'h8)) dut1 (.clk(clk), .rst_n(rst_n1), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks, n_errors;
    int cyc;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] exp_q[$];

    logic        p_cs[2], p_sck[2], p_mosi[2];
    logic [15:0] sh[2];
    int          nb[2], low_len[2], hi_len[2], last_low[2], last_hi[2];
    int          last_fall[2], period[2], done_cnt[2], viol[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial decoder of the MAX7219 pins: shifts on clk rising edges inside a cs-low window.
    task automatic mon(input int i, input logic cs, input logic sck, input logic mosi, input logic dn);
        if (dn) done_cnt[i]++;
        if (!cs) begin
            if (p_cs[i]) begin
                period[i]    = cyc - last_fall[i];
                last_fall[i] = cyc;
                nb[i] = 0; low_len[i] = 0; hi_len[i] = 0;
            end
            low_len[i]++;
            if (sck) hi_len[i]++;
            if (sck && !p_sck[i]) begin
                sh[i] = {sh[i][14:0], mosi};
                nb[i]++;
            end
            if (sck && p_sck[i] && (mosi != p_mosi[i])) viol[i]++;
        end else if (!p_cs[i]) begin
            last_low[i] = low_len[i];
            last_hi[i]  = hi_len[i];
            if (nb[i] == 16) begin
                if (i == 0) q0.push_back(sh[i]);
                else        q1.push_back(sh[i]);
            end
        end
        p_cs[i] = cs; p_sck[i] = sck; p_mosi[i] = mosi;
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0, b0.spi_cs, b0.spi_clk, b0.spi_mosi, b0.done);
        mon(1, b1.spi_cs, b1.spi_clk, b1.spi_mosi, b1.done);
    end

    // Reference: segments lit for each hex digit, as the no-decode byte {DP,A,B,C,D,E,F,G}.
    function automatic logic [6:0] abcdefg(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    task automatic push_init();
        exp_q.push_back(16'h0F00);
        exp_q.push_back(16'h0B07);
        exp_q.push_back(16'h0900);
        exp_q.push_back(16'h0A08);
        exp_q.push_back(16'h0C01);
    endtask

    task automatic push_refresh(input logic [31:0] v, input logic [7:0] d);
        for (int k = 0; k < 8; k++)
            exp_q.push_back({8'(k + 1), d[k], abcdefg(v[4*k +: 4])});
    endtask

    task automatic compare_q(input int i, input string tag);
        int n_got;
        n_got = (i == 0) ? q0.size() : q1.size();
        check({tag, "_count"}, 32'(n_got), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < n_got; k++)
            check($sformatf("%s_w%0d", tag, k), 32'((i == 0) ? q0[k] : q1[k]), 32'(exp_q[k]));
        exp_q.delete();
        if (i == 0) q0.delete(); else q1.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic logic cs_of(input int i);
        return (i == 0) ? b0.spi_cs : b1.spi_cs;
    endfunction

    function automatic logic busy_of(input int i);
        return (i == 0) ? b0.busy : b1.busy;
    endfunction

    task automatic upd(input int i, input logic [31:0] v, input logic [7:0] d);
        if (i == 0) begin b0.value = v; b0.dp = d; b0.update = 1'b1; end
        else        begin b1.value = v; b1.dp = d; b1.update = 1'b1; end
        tick();
        b0.update = 1'b0;
        b1.update = 1'b0;
    endtask

    task automatic wait_done(input int i, input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt[i] < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt[i] < target) check("done_timeout", 32'(done_cnt[i]), 32'(target));
    endtask

    task automatic run_refresh(input int i, input logic [31:0] v, input logic [7:0] d, input string tag);
        int base;
        base = done_cnt[i];
        push_refresh(v, d);
        upd(i, v, d);
        check({tag, "_busy_next"}, 32'(busy_of(i)), 32'd1);
        check({tag, "_cs_next"}, 32'(cs_of(i)), 32'd1);
        tick();
        check({tag, "_cs_2cyc"}, 32'(cs_of(i)), 32'd0);
        wait_done(i, base + 1, 2000);
        tick();
        check({tag, "_busy_fall"}, 32'(busy_of(i)), 32'd0);
        compare_q(i, tag);
    endtask

    initial begin
        int n, base;
        logic [31:0] v;
        logic [7:0]  d;
        n_checks = 0; n_errors = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            p_cs[i] = 1'b1; p_sck[i] = 1'b0; p_mosi[i] = 1'b0; sh[i] = '0;
            nb[i] = 0; low_len[i] = 0; hi_len[i] = 0; last_low[i] = 0; last_hi[i] = 0;
            last_fall[i] = 0; period[i] = 0; done_cnt[i] = 0; viol[i] = 0;
        end
        b0.value = '0; b0.dp = '0; b0.update = 1'b0;
        b1.value = '0; b1.dp = '0; b1.update = 1'b0;
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        repeat (4) tick();

        check("rst_cs",   32'(b0.spi_cs),   32'd1);
        check("rst_clk",  32'(b0.spi_clk),  32'd0);
        check("rst_mosi", 32'(b0.spi_mosi), 32'd0);
        check("rst_busy", 32'(b0.busy),     32'd1);
        check("rst_done", 32'(b0.done),     32'd0);
        check("rst1_cs",  32'(b1.spi_cs),   32'd1);
        check("rst1_busy", 32'(b1.busy),    32'd1);

        // Reset release: 5 init frames then a refresh of the all-zero shadow.
        push_init();
        push_refresh(32'h0, 8'h0);
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b0.done && n < 3000);
        check("init_done_cycles", 32'(n), 32'd1820);
        compare_q(0, "init");
        tick();
        check("init_busy_fall", 32'(b0.busy), 32'd0);
        push_init();
        push_refresh(32'h0, 8'h0);
        compare_q(1, "init_d1");

        run_refresh(0, 32'h01234567, 8'h00, "enc");
        check("frame_cs_low_d4", 32'(last_low[0]), 32'd132);
        check("frame_clk_hi_d4", 32'(last_hi[0]),  32'd64);
        check("frame_period_d4", 32'(period[0]),   32'd140);
        run_refresh(0, 32'hFEDCBA98, 8'h81, "hex_dp");
        for (int r = 0; r < 3; r++) begin
            v = $urandom;
            d = 8'($urandom);
            run_refresh(0, v, d, $sformatf("rand%0d", r));
        end

        // Two updates mid-refresh: only the latest shows, in an immediate second refresh.
        v = $urandom;
        d = 8'($urandom);
        base = done_cnt[0];
        push_refresh(v, d);
        push_refresh(32'h22222222, 8'h00);
        upd(0, v, d);
        repeat (300) tick();
        upd(0, 32'h11111111, 8'h00);
        repeat (200) tick();
        upd(0, 32'h22222222, 8'h00);
        wait_done(0, base + 2, 3000);
        tick();
        check("pend_busy_fall", 32'(b0.busy), 32'd0);
        repeat (400) tick();
        check("pend_done_count", 32'(done_cnt[0] - base), 32'd2);
        compare_q(0, "pend");

        // Reset pulse while bit 9 is being clocked (7th rising clk edge seen, clk high).
        v = $urandom;
        upd(0, v, 8'h00);
        n = 0;
        while (!(nb[0] == 7 && b0.spi_clk && !b0.spi_cs) && n < 2000) begin
            tick();
            n++;
        end
        check("reach_bit9", 32'(n < 2000), 32'd1);
        rst_n0 = 1'b0;
        tick();
        check("midrst_cs",   32'(b0.spi_cs),   32'd1);
        check("midrst_clk",  32'(b0.spi_clk),  32'd0);
        check("midrst_mosi", 32'(b0.spi_mosi), 32'd0);
        check("midrst_busy", 32'(b0.busy),     32'd1);
        check("midrst_done", 32'(b0.done),     32'd0);
        rst_n0 = 1'b1;
        q0.delete();
        base = done_cnt[0];
        push_init();
        push_refresh(32'h0, 8'h0);
        wait_done(0, base + 1, 2500);
        compare_q(0, "reinit");

        // CLK_DIV=1 instance.
        run_refresh(1, 32'h01234567, 8'h00, "enc_d1");
        check("frame_cs_low_d1", 32'(last_low[1]), 32'd33);
        check("frame_clk_hi_d1", 32'(last_hi[1]),  32'd16);
        check("frame_period_d1", 32'(period[1]),   32'd35);
        v = $urandom;
        d = 8'($urandom);
        run_refresh(1, v, d, "rand_d1");

        check("mosi_stable_d4", 32'(viol[0]), 32'd0);
        check("mosi_stable_d1", 32'(viol[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
